// File: rtl/ramb_asym_dp_sc_if.sv
// Bus bundle for the asymmetric dual-port RAM: port A (narrow), port B (wide)
// and the registered collision flag. Clock and reset travel as plain ports.
interface ramb_asym_dp_sc_if #(
  parameter int WIDTH_A = 4,
  parameter int RATIO   = 8,
  parameter int DEPTH_A = 4096
);
  localparam int WIDTH_B = WIDTH_A * RATIO;
  localparam int AWA     = $clog2(DEPTH_A);
  localparam int AWB     = AWA - $clog2(RATIO);

  // Port A (narrow)
  logic               ENA;
  logic               WEA;
  logic               SSRA;
  logic               REGCEA;
  logic [AWA-1:0]     ADDRA;
  logic [WIDTH_A-1:0] DIA;
  logic [WIDTH_A-1:0] DOA;

  // Port B (wide)
  logic               ENB;
  logic               WEB;
  logic               SSRB;
  logic               REGCEB;
  logic [AWB-1:0]     ADDRB;
  logic [WIDTH_B-1:0] DIB;
  logic [WIDTH_B-1:0] DOB;

  // Same-word collision pulse
  logic               COLL;

  modport master (
    output ENA, WEA, SSRA, REGCEA, ADDRA, DIA,
    output ENB, WEB, SSRB, REGCEB, ADDRB, DIB,
    input  DOA, DOB, COLL
  );

  modport slave (
    input  ENA, WEA, SSRA, REGCEA, ADDRA, DIA,
    input  ENB, WEB, SSRB, REGCEB, ADDRB, DIB,
    output DOA, DOB, COLL
  );
endinterface

// File: rtl/ramb_asym_dp_sc.sv
// Single-clock true dual-port RAM with asymmetric widths. Port A sees the
// storage as DEPTH_A words of WIDTH_A bits; port B sees the same storage as
// DEPTH_A/RATIO words of WIDTH_A*RATIO bits, lane 0 in the low bits.
// Each port has a write-mode-controlled output latch, an optional output
// register with its own clock enable, and a registered collision flag.
module ramb_asym_dp_sc #(
  parameter int    WIDTH_A      = 4,
  parameter int    RATIO        = 8,
  parameter int    DEPTH_A      = 4096,
  parameter string WRITE_MODE_A = "WRITE_FIRST",
  parameter string WRITE_MODE_B = "WRITE_FIRST",
  parameter int    DO_REG       = 0,
  parameter logic [WIDTH_A-1:0]       INIT_A  = '0,
  parameter logic [WIDTH_A*RATIO-1:0] INIT_B  = '0,
  parameter logic [WIDTH_A-1:0]       SRVAL_A = '0,
  parameter logic [WIDTH_A*RATIO-1:0] SRVAL_B = '0,
  parameter int    COLL_CHECK   = 1
) (
  input logic               CLK,
  input logic               RST,
  ramb_asym_dp_sc_if.slave  bus
);

  localparam int WIDTH_B = WIDTH_A * RATIO;
  localparam int SH      = $clog2(RATIO);
  localparam int AWA     = $clog2(DEPTH_A);
  localparam int AWB     = AWA - SH;
  localparam int DEPTH_B = DEPTH_A / RATIO;
  localparam int LW      = (SH > 0) ? SH : 1;

  localparam logic [1:0] MODE_WF = 2'd0;
  localparam logic [1:0] MODE_RF = 2'd1;
  localparam logic [1:0] MODE_NC = 2'd2;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                  (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

  // Storage is kept in wide words; port A addresses one lane of a word.
  logic [WIDTH_B-1:0] mem [DEPTH_B];

  logic [AWB-1:0]     wordA;
  logic [LW-1:0]      laneA;
  logic [WIDTH_B-1:0] oldWordA;
  logic [WIDTH_A-1:0] oldLaneA;
  logic [WIDTH_B-1:0] oldWordB;

  logic [WIDTH_A-1:0] latA;
  logic [WIDTH_B-1:0] latB;
  logic [WIDTH_A-1:0] regA;
  logic [WIDTH_B-1:0] regB;
  logic               collQ;

  assign wordA    = AWB'(bus.ADDRA >> SH);
  assign laneA    = LW'(bus.ADDRA & AWA'(RATIO - 1));
  assign oldWordA = mem[wordA];
  assign oldWordB = mem[bus.ADDRB];

  // Pick the addressed lane out of the pre-edge contents of port A's word
  always_comb begin
    oldLaneA = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (laneA == LW'(l)) begin
        oldLaneA = oldWordA[l*WIDTH_A +: WIDTH_A];
      end
    end
  end

  // Storage writes; B is applied last so it wins a shared lane when both write
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (bus.ENA && bus.WEA) begin
        for (int l = 0; l < RATIO; l++) begin
          if (laneA == LW'(l)) begin
            mem[wordA][l*WIDTH_A +: WIDTH_A] <= bus.DIA;
          end
        end
      end
      if (bus.ENB && bus.WEB) begin
        mem[bus.ADDRB] <= bus.DIB;
      end
    end
  end

  // Port A output latch: write mode decides what a write shows; reads see pre-edge data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      latA <= INIT_A;
    end else if (bus.ENA) begin
      if ((DO_REG == 0) && bus.SSRA) begin
        latA <= SRVAL_A;
      end else if (bus.WEA) begin
        if (MODE_A == MODE_WF) begin
          latA <= bus.DIA;
        end else if (MODE_A == MODE_RF) begin
          latA <= oldLaneA;
        end
      end else begin
        latA <= oldLaneA;
      end
    end
  end

  // Port B output latch, same rules as port A at full width
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      latB <= INIT_B;
    end else if (bus.ENB) begin
      if ((DO_REG == 0) && bus.SSRB) begin
        latB <= SRVAL_B;
      end else if (bus.WEB) begin
        if (MODE_B == MODE_WF) begin
          latB <= bus.DIB;
        end else if (MODE_B == MODE_RF) begin
          latB <= oldWordB;
        end
      end else begin
        latB <= oldWordB;
      end
    end
  end

  // Port A output register: SSR acts here (not in the latch) when DO_REG is set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regA <= INIT_A;
    end else if (bus.REGCEA) begin
      regA <= bus.SSRA ? SRVAL_A : latA;
    end
  end

  // Port B output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regB <= INIT_B;
    end else if (bus.REGCEB) begin
      regB <= bus.SSRB ? SRVAL_B : latB;
    end
  end

  // Collision flag: both ports on the same wide word with at least one writing
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      collQ <= 1'b0;
    end else begin
      collQ <= (COLL_CHECK != 0) && bus.ENA && bus.ENB &&
               (wordA == bus.ADDRB) && (bus.WEA || bus.WEB);
    end
  end

  assign bus.DOA  = (DO_REG != 0) ? regA : latA;
  assign bus.DOB  = (DO_REG != 0) ? regB : latB;
  assign bus.COLL = collQ;

endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// Directed bench for ramb_asym_dp_sc. Four instances share one stimulus:
// 0 = WRITE_FIRST (INIT_A=5, SRVAL_B=CAFEF00D), 1 = READ_FIRST on A,
// 2 = NO_CHANGE on A, 3 = DO_REG=1 with SRVAL_B=DEADBEEF.
module tb_ramb_asym_dp_sc;

  logic clk = 1'b0;
  logic rst;

  logic        ena, wea, ssra, regcea;
  logic [11:0] addra;
  logic [3:0]  dia;
  logic        enb, web, ssrb, regceb;
  logic [8:0]  addrb;
  logic [31:0] dib;

  logic [3:0]  doaObs  [4];
  logic [31:0] dobObs  [4];
  logic        collObs [4];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ramb_asym_dp_sc_if #(.WIDTH_A(4), .RATIO(8), .DEPTH_A(4096)) bus [4] ();

  // Fan the shared stimulus out to every instance and collect outputs
  for (genvar g = 0; g < 4; g++) begin : gDrive
    assign bus[g].ENA    = ena;
    assign bus[g].WEA    = wea;
    assign bus[g].SSRA   = ssra;
    assign bus[g].REGCEA = regcea;
    assign bus[g].ADDRA  = addra;
    assign bus[g].DIA    = dia;
    assign bus[g].ENB    = enb;
    assign bus[g].WEB    = web;
    assign bus[g].SSRB   = ssrb;
    assign bus[g].REGCEB = regceb;
    assign bus[g].ADDRB  = addrb;
    assign bus[g].DIB    = dib;
    assign doaObs[g]     = bus[g].DOA;
    assign dobObs[g]     = bus[g].DOB;
    assign collObs[g]    = bus[g].COLL;
  end

  ramb_asym_dp_sc #(.INIT_A(4'h5), .SRVAL_B(32'hCAFEF00D)) uWf (
    .CLK(clk), .RST(rst), .bus(bus[0]));
  ramb_asym_dp_sc #(.WRITE_MODE_A("READ_FIRST")) uRf (
    .CLK(clk), .RST(rst), .bus(bus[1]));
  ramb_asym_dp_sc #(.WRITE_MODE_A("NO_CHANGE")) uNc (
    .CLK(clk), .RST(rst), .bus(bus[2]));
  ramb_asym_dp_sc #(.DO_REG(1), .SRVAL_B(32'hDEADBEEF)) uReg (
    .CLK(clk), .RST(rst), .bus(bus[3]));

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Present one operation, take one rising edge, sample 1 time unit later
  task automatic applyStimulus(input logic ea, input logic wa, input logic [11:0] aa,
                               input logic [3:0] da, input logic eb, input logic wb,
                               input logic [8:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b0, 1'b0, 9'd0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    ssra = 1'b0; regcea = 1'b1; ssrb = 1'b0; regceb = 1'b1;
    idle();
    checkOutput("rst_doa_init_a", 32'(doaObs[0]), 32'h5);
    checkOutput("rst_doa_default", 32'(doaObs[3]), 32'h0);
    checkOutput("rst_dob_init_b", dobObs[0], 32'h0);
    checkOutput("rst_coll", 32'(collObs[0]), 32'h0);
    rst = 1'b0;

    $display("[TB] B write then A lane reads");
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b1, 9'd5, 32'h12345678);
    checkOutput("b_write_first", dobObs[0], 32'h12345678);
    checkOutput("reg_dob_lag", dobObs[3], 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 12'(40 + i), 4'h0, 1'b0, 1'b0, 9'd0, 32'h0);
      checkOutput($sformatf("a_read_lane%0d", i), 32'(doaObs[0]), 32'(8 - i));
      if (i == 0) checkOutput("reg_dob_after_write", dobObs[3], 32'h12345678);
      else checkOutput($sformatf("reg_doa_lane%0d", i - 1), 32'(doaObs[3]), 32'(9 - i));
    end

    $display("[TB] A lane write, modes, B wide read");
    applyStimulus(1'b1, 1'b1, 12'd41, 4'hF, 1'b0, 1'b0, 9'd0, 32'h0);
    checkOutput("wf_doa_new", 32'(doaObs[0]), 32'hF);
    checkOutput("rf_doa_prior", 32'(doaObs[1]), 32'h7);
    checkOutput("nc_doa_hold", 32'(doaObs[2]), 32'h1);
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b0, 9'd5, 32'h0);
    checkOutput("b_read_merged", dobObs[0], 32'h123456F8);
    checkOutput("reg_dob_one_edge", dobObs[3], 32'h12345678);
    idle();
    checkOutput("reg_dob_two_edges", dobObs[3], 32'h123456F8);
    applyStimulus(1'b1, 1'b1, 12'd100, 4'h9, 1'b0, 1'b0, 9'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 12'd100, 4'h3, 1'b0, 1'b0, 9'd0, 32'h0);
    checkOutput("wf_over9", 32'(doaObs[0]), 32'h3);
    checkOutput("rf_over9", 32'(doaObs[1]), 32'h9);
    checkOutput("nc_over9", 32'(doaObs[2]), 32'h1);

    $display("[TB] collisions");
    applyStimulus(1'b1, 1'b1, 12'd40, 4'hA, 1'b1, 1'b1, 9'd5, 32'hFFFFFFFF);
    checkOutput("coll_both_write", 32'(collObs[0]), 32'h1);
    checkOutput("coll_wf_doa", 32'(doaObs[0]), 32'hA);
    checkOutput("coll_rf_doa", 32'(doaObs[1]), 32'h8);
    checkOutput("coll_dob", dobObs[0], 32'hFFFFFFFF);
    idle();
    checkOutput("coll_one_cycle", 32'(collObs[0]), 32'h0);
    applyStimulus(1'b1, 1'b0, 12'd40, 4'h0, 1'b0, 1'b0, 9'd0, 32'h0);
    checkOutput("coll_b_wins_lane", 32'(doaObs[0]), 32'hF);
    applyStimulus(1'b1, 1'b0, 12'd41, 4'h0, 1'b1, 1'b1, 9'd5, 32'h11111111);
    checkOutput("coll_a_reads_prior", 32'(doaObs[0]), 32'hF);
    checkOutput("coll_a_read", 32'(collObs[0]), 32'h1);
    applyStimulus(1'b1, 1'b1, 12'd42, 4'h2, 1'b1, 1'b0, 9'd5, 32'h0);
    checkOutput("coll_back_to_back", 32'(collObs[0]), 32'h1);
    checkOutput("coll_b_reads_prior", dobObs[0], 32'h11111111);
    idle();
    checkOutput("coll_cleared", 32'(collObs[0]), 32'h0);
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b0, 9'd5, 32'h0);
    checkOutput("b_read_after_a_lane2", dobObs[0], 32'h11111211);

    $display("[TB] SSR and output register enable");
    ssrb = 1'b1;
    idle();
    checkOutput("reg_ssr", dobObs[3], 32'hDEADBEEF);
    checkOutput("latch_ssr_needs_en", dobObs[0], 32'h11111211);
    ssrb = 1'b0; regceb = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b0, 9'd5, 32'h0);
    checkOutput("regce_hold", dobObs[3], 32'hDEADBEEF);
    regceb = 1'b1;
    idle();
    checkOutput("regce_reload", dobObs[3], 32'h11111211);
    ssrb = 1'b1;
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b1, 9'd6, 32'h22222222);
    checkOutput("ssr_latch_srval", dobObs[0], 32'hCAFEF00D);
    ssrb = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b0, 9'd6, 32'h0);
    checkOutput("ssr_write_kept", dobObs[0], 32'h22222222);

    $display("[TB] async reset mid-burst");
    applyStimulus(1'b1, 1'b0, 12'd43, 4'h0, 1'b1, 1'b1, 9'd5, 32'h33333333);
    checkOutput("pre_rst_coll", 32'(collObs[0]), 32'h1);
    checkOutput("pre_rst_doa", 32'(doaObs[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_doa", 32'(doaObs[0]), 32'h5);
    checkOutput("async_rst_coll", 32'(collObs[0]), 32'h0);
    checkOutput("async_rst_dob", dobObs[0], 32'h0);
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b1, 9'd5, 32'h44444444);
    checkOutput("rst_holds_doa", 32'(doaObs[0]), 32'h5);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'd0, 4'h0, 1'b1, 1'b0, 9'd5, 32'h0);
    checkOutput("mem_kept_word5", dobObs[0], 32'h33333333);
    applyStimulus(1'b1, 1'b0, 12'd40, 4'h0, 1'b1, 1'b0, 9'd6, 32'h0);
    checkOutput("mem_kept_lane40", 32'(doaObs[0]), 32'h3);
    checkOutput("mem_kept_word6", dobObs[0], 32'h22222222);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
